// File: rtl/ltl_mon_pkg.sv
// Shared types for the LTL monitor symbol interface: symbol width, symbol type
// and the streamer session FSM states.
package ltl_mon_pkg;

    localparam int SYM_W = 8;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        STREAM,
        DRAIN
    } state_t;

endpackage

// File: rtl/ltl_sym_fifo.sv
// Single-clock symbol FIFO. Occupancy is tracked by a separate count so that
// full and empty stay unambiguous. A push while full is accepted only when a pop
// frees a slot in the same cycle.
module ltl_sym_fifo
    import ltl_mon_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  sym_t          din,
    output sym_t          dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    sym_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ltl_symbol_streamer.sv
// Packs per-cycle proposition flags into symbols, buffers them and streams them
// into one monitor automaton, timing the automaton reset so that its first
// data cycle carries the first symbol.
module ltl_symbol_streamer
    import ltl_mon_pkg::*;
#(
    parameter int NUM_PROPS   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int INIT_CYCLES = 2,
    parameter int DEDUP       = 0,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic                 prop_valid_i,
    input  logic [NUM_PROPS-1:0] prop_i,
    input  logic                 mon_grant_i,
    output logic [SYM_W-1:0]     mon_symbol_o,
    output logic                 mon_run_o,
    output logic                 mon_reset_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic [CNT_W-1:0]     sym_count_o,
    output logic [CNT_W-1:0]     drop_count_o
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int FCW    = $clog2(FIFO_DEPTH + 1);

    state_t                state;
    logic [INIT_W-1:0]     init_cnt;
    logic [NUM_PROPS-1:0]  last_vec;
    logic                  have_last;

    sym_t                  push_sym;
    sym_t                  fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCW-1:0]        fifo_count;

    logic                  init_done;
    logic                  dup_hit;
    logic                  push_req;
    logic                  issue;
    logic                  drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign push_sym  = sym_t'(prop_i);
    assign init_done = (init_cnt >= INIT_W'(INIT_CYCLES));
    assign dup_hit   = (DEDUP != 0) && have_last && (prop_i == last_vec);
    assign push_req  = prop_valid_i && (state == ARM || state == STREAM) && !dup_hit;

    // In ARM the first issue is also the edge that releases the automaton reset.
    assign issue = !fifo_empty && mon_grant_i &&
                   ((state == ARM && init_done && enable_i) ||
                    state == STREAM || state == DRAIN);
    assign drop  = push_req && fifo_full && !issue;

    ltl_sym_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (state == IDLE),
        .push  (push_req),
        .pop   (issue),
        .din   (push_sym),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            init_cnt     <= '0;
            have_last    <= 1'b0;
            mon_symbol_o <= '0;
            mon_run_o    <= 1'b0;
            mon_reset_o  <= 1'b1;
            busy_o       <= 1'b0;
            overflow_o   <= 1'b0;
            sym_count_o  <= '0;
            drop_count_o <= '0;
        end else begin
            mon_run_o <= issue;
            if (issue) begin
                mon_symbol_o <= fifo_head;
                sym_count_o  <= sat_inc(sym_count_o);
            end
            if (drop) begin
                overflow_o   <= 1'b1;
                drop_count_o <= sat_inc(drop_count_o);
            end
            if (push_req) begin
                last_vec  <= prop_i;
                have_last <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state        <= ARM;
                        busy_o       <= 1'b1;
                        mon_reset_o  <= 1'b1;
                        init_cnt     <= '0;
                        have_last    <= 1'b0;
                        overflow_o   <= 1'b0;
                        sym_count_o  <= '0;
                        drop_count_o <= '0;
                    end
                end
                ARM: begin
                    if (!enable_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        if (!init_done) begin
                            init_cnt <= init_cnt + INIT_W'(1);
                        end
                        if (issue) begin
                            state       <= STREAM;
                            mon_reset_o <= 1'b0;
                        end
                    end
                end
                STREAM: begin
                    if (!enable_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_count == '0) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        mon_reset_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ltl_symbol_streamer.sv
// Directed bench for ltl_symbol_streamer: a default instance plus a DEDUP=1
// instance driven by the same stimulus.
module tb_ltl_symbol_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        prop_valid;
    logic [7:0]  prop;
    logic        grant;

    logic [7:0]  sym0, sym1;
    logic        run0, run1, mrst0, mrst1, busy0, busy1, ovf0, ovf1;
    logic [15:0] scnt0, scnt1, dcnt0, dcnt1;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ltl_symbol_streamer #(.DEDUP(0)) dut0 (
        .clk(clk), .reset(reset), .enable_i(enable), .prop_valid_i(prop_valid),
        .prop_i(prop), .mon_grant_i(grant), .mon_symbol_o(sym0), .mon_run_o(run0),
        .mon_reset_o(mrst0), .busy_o(busy0), .overflow_o(ovf0),
        .sym_count_o(scnt0), .drop_count_o(dcnt0)
    );

    ltl_symbol_streamer #(.DEDUP(1)) dut1 (
        .clk(clk), .reset(reset), .enable_i(enable), .prop_valid_i(prop_valid),
        .prop_i(prop), .mon_grant_i(grant), .mon_symbol_o(sym1), .mon_run_o(run1),
        .mon_reset_o(mrst1), .busy_o(busy1), .overflow_o(ovf1),
        .sym_count_o(scnt1), .drop_count_o(dcnt1)
    );

    always @(negedge clk) begin
        if (run0) q0.push_back(sym0);
        if (run1) q1.push_back(sym1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        prop_valid = 1'b1;
        prop       = v;
        tick();
        prop_valid = 1'b0;
    endtask

    // Reset, then open a session and wait until the init window has elapsed.
    task automatic new_session();
        reset = 1'b1; enable = 1'b0; prop_valid = 1'b0; grant = 1'b0;
        tick();
        reset = 1'b0;
        q0.delete(); q1.delete();
        enable = 1'b1; grant = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int rst_hi;
        bit got_run;

        reset = 1'b1; enable = 1'b0; prop_valid = 1'b0; prop = 8'h00; grant = 1'b0;
        repeat (2) tick();
        check("rst_symbol",   sym0,  0);
        check("rst_run",      run0,  0);
        check("rst_monreset", mrst0, 1);
        check("rst_busy",     busy0, 0);
        check("rst_overflow", ovf0,  0);
        check("rst_symcnt",   scnt0, 0);
        check("rst_dropcnt",  dcnt0, 0);

        // Start: first symbol lands in the first cycle with mon_reset_o low.
        reset = 1'b0; enable = 1'b1; grant = 1'b1; prop_valid = 1'b1; prop = 8'h05;
        rst_hi = 0; got_run = 1'b0;
        for (int i = 0; i < 20 && !got_run; i++) begin
            tick();
            if (run0) got_run = 1'b1;
            else if (mrst0) rst_hi++;
        end
        prop_valid = 1'b0;
        check("start_run_seen",  got_run, 1);
        check("start_reset_len", (rst_hi >= 2), 1);
        check("start_monreset",  mrst0, 0);
        check("start_symbol",    sym0, 8'h05);
        check("start_symcnt",    scnt0, 1);

        // Grant stall for 5 cycles after the first symbol.
        new_session();
        push(8'h10);
        push(8'h20);
        check("stall_first_run", run0, 1);
        check("stall_first_sym", sym0, 8'h10);
        grant = 1'b0;
        push(8'h30);
        check("stall_run_low", run0, 0);
        repeat (4) tick();
        grant = 1'b1;
        repeat (5) tick();
        check("stall_qsize", q0.size(), 3);
        check("stall_q1", q0[1], 8'h20);
        check("stall_q2", q0[2], 8'h30);
        check("stall_drop", dcnt0, 0);
        check("stall_symcnt", scnt0, 3);

        // Overflow: 10 pushes into an 8-entry FIFO with grant low.
        new_session();
        push(8'h01);
        tick();
        grant = 1'b0;
        for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
        check("ovf_flag", ovf0, 1);
        check("ovf_drop", dcnt0, 2);
        grant = 1'b1;
        repeat (12) tick();
        check("ovf_qsize", q0.size(), 9);
        for (int i = 0; i < 8; i++) check("ovf_sym", q0[i + 1], 8'h40 + i);
        check("ovf_drop_hold", dcnt0, 2);
        check("ovf_symcnt", scnt0, 9);

        // Full FIFO with simultaneous push and pop.
        new_session();
        push(8'h01);
        tick();
        grant = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
        check("full_no_drop_yet", dcnt0, 0);
        grant = 1'b1;
        push(8'hAA);
        check("full_pop_sym", sym0, 8'h50);
        check("full_drop", dcnt0, 0);
        check("full_ovf", ovf0, 0);
        repeat (7) tick();
        check("full_last_orig", sym0, 8'h57);
        tick();
        check("full_aa_run", run0, 1);
        check("full_aa_sym", sym0, 8'hAA);

        // DEDUP on dut1; dut0 sees the same vectors without suppression.
        new_session();
        push(8'h03); push(8'h03); push(8'h07); push(8'h07); push(8'h03);
        repeat (8) tick();
        check("dedup_qsize", q1.size(), 3);
        check("dedup_q0", q1[0], 8'h03);
        check("dedup_q1", q1[1], 8'h07);
        check("dedup_q2", q1[2], 8'h03);
        check("dedup_symcnt", scnt1, 3);
        check("nodedup_symcnt", scnt0, 5);

        // Drain three queued symbols after enable drops.
        new_session();
        push(8'h01);
        tick();
        grant = 1'b0;
        push(8'h61); push(8'h62); push(8'h63);
        enable = 1'b0; grant = 1'b1;
        tick();
        check("drain_busy", busy0, 1);
        check("drain_sym1", sym0, 8'h61);
        tick();
        tick();
        check("drain_sym3", sym0, 8'h63);
        check("drain_run3", run0, 1);
        tick();
        check("drain_idle_busy", busy0, 0);
        check("drain_idle_monreset", mrst0, 1);
        check("drain_idle_run", run0, 0);
        check("drain_qsize", q0.size(), 4);

        // Reset asserted mid-stream with a symbol still queued.
        new_session();
        push(8'h01); push(8'h02); push(8'h03);
        check("midrst_streaming", run0, 1);
        reset = 1'b1;
        tick();
        check("midrst_run", run0, 0);
        check("midrst_symcnt", scnt0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_monreset", mrst0, 1);
        check("midrst_symbol", sym0, 0);
        reset = 1'b0;
        q0.delete();
        repeat (8) tick();
        check("midrst_fifo_empty", q0.size(), 0);
        check("midrst_rearm_busy", busy0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
